// File: rtl/data_cache_pkg.sv
// Shared widths, command/status codes and FSM states for the data cache.
// Also provides the byte-enable helper used by the store merge path.
package data_cache_pkg;

   localparam int ADDR_WIDTH       = 17;
   localparam int LEN              = 32;
   localparam int BYTE_SIZE        = 8;
   localparam int CACHE_SIZE       = 16;
   localparam int CACHE_INDEX_SIZE = 4;

   localparam int TAG_WIDTH   = ADDR_WIDTH - CACHE_INDEX_SIZE - 2;
   localparam int WADDR_WIDTH = ADDR_WIDTH - 2;
   localparam int NBYTES      = LEN / BYTE_SIZE;

   localparam logic [1:0] D_CACHE_NOP   = 2'd0;
   localparam logic [1:0] D_CACHE_LOAD  = 2'd1;
   localparam logic [1:0] D_CACHE_STORE = 2'd2;

   localparam logic [1:0] D_CACHE_RESTING = 2'd0;
   localparam logic [1:0] D_CACHE_STALL   = 2'd1;

   localparam logic [2:0] ONE_BYTE  = 3'd0;
   localparam logic [2:0] TWO_BYTE  = 3'd1;
   localparam logic [2:0] FOUR_BYTE = 3'd2;

   typedef enum logic [1:0] {
      DC_IDLE      = 2'd0,
      DC_WRITEBACK = 2'd1,
      DC_REFILL    = 2'd2
   } dc_state_e;

   // Byte lanes touched by an access; unknown sizes act as a full word.
   function automatic logic [NBYTES-1:0] byte_enable(
      input logic [2:0] dt,
      input logic [1:0] off
   );
      logic [NBYTES-1:0] be;
      case (dt)
         ONE_BYTE: be = 4'b0001 << off;
         TWO_BYTE: be = off[1] ? 4'b1100 : 4'b0011;
         default:  be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/d_cache_line_array.sv
// Valid/dirty/tag/data storage for the direct-mapped data cache.
// Ports: async read by rd_index; byte-masked store write (sets dirty);
// install port (valid=1, dirty=0); everything cleared on async rst.
module d_cache_line_array
   import data_cache_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CACHE_INDEX_SIZE-1:0] rd_index,
   output logic                        rd_valid,
   output logic                        rd_dirty,
   output logic [TAG_WIDTH-1:0]        rd_tag,
   output logic [LEN-1:0]              rd_data,
   input  logic                        wr_en,
   input  logic [CACHE_INDEX_SIZE-1:0] wr_index,
   input  logic [NBYTES-1:0]           wr_be,
   input  logic [LEN-1:0]              wr_data,
   input  logic                        inst_en,
   input  logic [CACHE_INDEX_SIZE-1:0] inst_index,
   input  logic [TAG_WIDTH-1:0]        inst_tag,
   input  logic [LEN-1:0]              inst_data
);

   logic [CACHE_SIZE-1:0] valid_q, valid_d;
   logic [CACHE_SIZE-1:0] dirty_q, dirty_d;
   logic [TAG_WIDTH-1:0]  tag_q  [CACHE_SIZE];
   logic [TAG_WIDTH-1:0]  tag_d  [CACHE_SIZE];
   logic [LEN-1:0]        data_q [CACHE_SIZE];
   logic [LEN-1:0]        data_d [CACHE_SIZE];

   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) begin
               data_d[wr_index][b*BYTE_SIZE +: BYTE_SIZE] =
                  wr_data[b*BYTE_SIZE +: BYTE_SIZE];
            end
         end
         dirty_d[wr_index] = 1'b1;
      end
      if (inst_en) begin
         valid_d[inst_index] = 1'b1;
         dirty_d[inst_index] = 1'b0;
         tag_d[inst_index]   = inst_tag;
         data_d[inst_index]  = inst_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < CACHE_SIZE; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         for (int i = 0; i < CACHE_SIZE; i++) begin
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache, one word per line.
// Requester side: cache_vis_signal/mem_vis_addr/data_type/cache_written_data
// in, mem_data/d_cache_status out (comb). Memory side: registered
// mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready in.
module data_cache
   import data_cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             cache_vis_signal,
   input  logic [ADDR_WIDTH-1:0]  mem_vis_addr,
   input  logic [2:0]             data_type,
   input  logic [LEN-1:0]         cache_written_data,
   output logic [LEN-1:0]         mem_data,
   output logic [1:0]             d_cache_status,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [WADDR_WIDTH-1:0] mem_addr,
   output logic [LEN-1:0]         mem_wdata,
   input  logic [LEN-1:0]         mem_rdata,
   input  logic                   mem_ready
);

   logic [1:0]                  req_off;
   logic [CACHE_INDEX_SIZE-1:0] req_idx;
   logic [TAG_WIDTH-1:0]        req_tag;
   logic [WADDR_WIDTH-1:0]      req_waddr;
   logic                        is_req;
   logic                        hit;

   logic                        rd_valid;
   logic                        rd_dirty;
   logic [TAG_WIDTH-1:0]        rd_tag;
   logic [LEN-1:0]              rd_data;

   logic                        wr_en;
   logic [NBYTES-1:0]           wr_be;
   logic [LEN-1:0]              wr_data;
   logic                        inst_en;

   dc_state_e                   state_q, state_d;
   logic                        mem_req_q, mem_req_d;
   logic                        mem_we_q, mem_we_d;
   logic [WADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
   logic [LEN-1:0]              mem_wdata_q, mem_wdata_d;
   // Word address of the outstanding miss; survives a withdrawn request.
   logic [WADDR_WIDTH-1:0]      miss_waddr_q, miss_waddr_d;

   assign req_off   = mem_vis_addr[1:0];
   assign req_idx   = mem_vis_addr[CACHE_INDEX_SIZE+1:2];
   assign req_tag   = mem_vis_addr[ADDR_WIDTH-1:CACHE_INDEX_SIZE+2];
   assign req_waddr = mem_vis_addr[ADDR_WIDTH-1:2];
   assign is_req    = (cache_vis_signal == D_CACHE_LOAD) ||
                      (cache_vis_signal == D_CACHE_STORE);
   assign hit       = rd_valid && (rd_tag == req_tag);

   d_cache_line_array u_lines (
      .clk        (clk),
      .rst        (rst),
      .rd_index   (req_idx),
      .rd_valid   (rd_valid),
      .rd_dirty   (rd_dirty),
      .rd_tag     (rd_tag),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_index   (req_idx),
      .wr_be      (wr_be),
      .wr_data    (wr_data),
      .inst_en    (inst_en),
      .inst_index (miss_waddr_q[CACHE_INDEX_SIZE-1:0]),
      .inst_tag   (miss_waddr_q[WADDR_WIDTH-1:CACHE_INDEX_SIZE]),
      .inst_data  (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= DC_IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         miss_waddr_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         miss_waddr_q <= miss_waddr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      miss_waddr_d = miss_waddr_q;
      case (state_q)
         DC_IDLE: begin
            if (is_req && !hit) begin
               miss_waddr_d = req_waddr;
               mem_req_d    = 1'b1;
               mem_wdata_d  = rd_data;
               if (rd_valid && rd_dirty) begin
                  state_d    = DC_WRITEBACK;
                  mem_we_d   = 1'b1;
                  mem_addr_d = {rd_tag, req_idx};
               end else begin
                  state_d    = DC_REFILL;
                  mem_we_d   = 1'b0;
                  mem_addr_d = req_waddr;
               end
            end
         end
         DC_WRITEBACK: begin
            if (mem_ready) begin
               state_d    = DC_REFILL;
               mem_we_d   = 1'b0;
               mem_addr_d = miss_waddr_q;
            end
         end
         DC_REFILL: begin
            if (mem_ready) begin
               state_d   = DC_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = DC_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      d_cache_status = D_CACHE_STALL;
      mem_data       = '0;
      wr_en          = 1'b0;
      wr_be          = byte_enable(data_type, req_off);
      wr_data        = cache_written_data;
      inst_en        = (state_q == DC_REFILL) && mem_ready;
      case (data_type)
         ONE_BYTE: wr_data = {NBYTES{cache_written_data[BYTE_SIZE-1:0]}};
         TWO_BYTE: wr_data = {(NBYTES/2){cache_written_data[2*BYTE_SIZE-1:0]}};
         default:  wr_data = cache_written_data;
      endcase
      if (state_q == DC_IDLE) begin
         if (!is_req || hit) begin
            d_cache_status = D_CACHE_RESTING;
         end
         if (hit && cache_vis_signal == D_CACHE_STORE) begin
            wr_en = 1'b1;
         end
         if (hit && cache_vis_signal == D_CACHE_LOAD) begin
            case (data_type)
               ONE_BYTE: begin
                  mem_data[BYTE_SIZE-1:0] =
                     rd_data[{req_off, 3'b000} +: BYTE_SIZE];
               end
               TWO_BYTE: begin
                  mem_data[2*BYTE_SIZE-1:0] =
                     rd_data[{req_off[1], 4'b0000} +: 2*BYTE_SIZE];
               end
               default: mem_data = rd_data;
            endcase
         end
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: hand-computed vectors, memory side
// driven step by step, immediate assertions at each check point.
module tb_data_cache;
   import data_cache_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             cache_vis_signal;
   logic [ADDR_WIDTH-1:0]  mem_vis_addr;
   logic [2:0]             data_type;
   logic [LEN-1:0]         cache_written_data;
   logic [LEN-1:0]         mem_data;
   logic [1:0]             d_cache_status;
   logic                   mem_req;
   logic                   mem_we;
   logic [WADDR_WIDTH-1:0] mem_addr;
   logic [LEN-1:0]         mem_wdata;
   logic [LEN-1:0]         mem_rdata;
   logic                   mem_ready;

   int ntests = 0;
   int nfail  = 0;

   data_cache dut (
      .clk                (clk),
      .rst                (rst),
      .cache_vis_signal   (cache_vis_signal),
      .mem_vis_addr       (mem_vis_addr),
      .data_type          (data_type),
      .cache_written_data (cache_written_data),
      .mem_data           (mem_data),
      .d_cache_status     (d_cache_status),
      .mem_req            (mem_req),
      .mem_we             (mem_we),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_rdata          (mem_rdata),
      .mem_ready          (mem_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] s, input logic [2:0] dt,
                      input logic [16:0] a, input logic [31:0] d);
      cache_vis_signal   = s;
      data_type          = dt;
      mem_vis_addr       = a;
      cache_written_data = d;
      #1;
   endtask

   // One-cycle mem_ready pulse captured at the next posedge.
   task automatic mem_done(input logic [31:0] d);
      mem_rdata = d;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      cache_vis_signal = D_CACHE_NOP;
      mem_vis_addr = '0;
      data_type = FOUR_BYTE;
      cache_written_data = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_status", 32'(d_cache_status), 32'(D_CACHE_RESTING));
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);

      // Cold miss, clean victim: straight to refill.
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00010, 32'd0);
      chk("t1_stall", 32'(d_cache_status), 32'(D_CACHE_STALL));
      chk("t1_req_pre", 32'(mem_req), 32'd0);
      tick();
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_we", 32'(mem_we), 32'd0);
      chk("t1_addr", 32'(mem_addr), 32'h004);
      mem_done(32'hDEADBEEF);
      chk("t1_rest", 32'(d_cache_status), 32'(D_CACHE_RESTING));
      chk("t1_data", mem_data, 32'hDEADBEEF);
      chk("t1_req_off", 32'(mem_req), 32'd0);

      // Byte store hit, then readback.
      req(D_CACHE_STORE, ONE_BYTE, 17'h00011, 32'h000000AB);
      chk("t2_st_rest", 32'(d_cache_status), 32'(D_CACHE_RESTING));
      tick();
      chk("t2_no_req", 32'(mem_req), 32'd0);
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00010, 32'd0);
      chk("t2_data", mem_data, 32'hDEADABEF);

      // Conflict miss on a dirty line: write-back then refill.
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00050, 32'd0);
      chk("t3_stall", 32'(d_cache_status), 32'(D_CACHE_STALL));
      tick();
      chk("t3_wb_req", 32'(mem_req), 32'd1);
      chk("t3_wb_we", 32'(mem_we), 32'd1);
      chk("t3_wb_addr", 32'(mem_addr), 32'h004);
      chk("t3_wb_wdata", mem_wdata, 32'hDEADABEF);
      tick();
      chk("t3_wb_hold", 32'(mem_req), 32'd1);
      mem_done(32'h12345678);
      chk("t3_rf_req", 32'(mem_req), 32'd1);
      chk("t3_rf_we", 32'(mem_we), 32'd0);
      chk("t3_rf_addr", 32'(mem_addr), 32'h014);
      chk("t3_rf_stall", 32'(d_cache_status), 32'(D_CACHE_STALL));
      mem_done(32'h12345678);
      chk("t3_rest", 32'(d_cache_status), 32'(D_CACHE_RESTING));
      chk("t3_data", mem_data, 32'h12345678);

      // Evicted clean line: no write-back; sub-word loads.
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00010, 32'd0);
      tick();
      chk("t4_we", 32'(mem_we), 32'd0);
      chk("t4_addr", 32'(mem_addr), 32'h004);
      mem_done(32'hDEADABEF);
      chk("t4_word", mem_data, 32'hDEADABEF);
      req(D_CACHE_LOAD, TWO_BYTE, 17'h00012, 32'd0);
      chk("t4_half_hi", mem_data, 32'h0000DEAD);
      req(D_CACHE_LOAD, ONE_BYTE, 17'h00013, 32'd0);
      chk("t4_byte3", mem_data, 32'h000000DE);
      req(D_CACHE_LOAD, TWO_BYTE, 17'h00010, 32'd0);
      chk("t4_half_lo", mem_data, 32'h0000ABEF);

      // Store miss allocates, then merges the half-word.
      req(D_CACHE_STORE, TWO_BYTE, 17'h00022, 32'h0000BEEF);
      chk("wa_stall", 32'(d_cache_status), 32'(D_CACHE_STALL));
      tick();
      chk("wa_addr", 32'(mem_addr), 32'h008);
      mem_done(32'h11223344);
      chk("wa_rest", 32'(d_cache_status), 32'(D_CACHE_RESTING));
      tick();
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00022, 32'd0);
      chk("wa_data", mem_data, 32'hBEEF3344);

      // Request withdrawn mid-miss: line still installed.
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00030, 32'd0);
      tick();
      req(D_CACHE_NOP, FOUR_BYTE, 17'h00000, 32'd0);
      mem_done(32'h00000055);
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00030, 32'd0);
      chk("wd_hit", 32'(d_cache_status), 32'(D_CACHE_RESTING));
      chk("wd_data", mem_data, 32'h00000055);

      // Reset during refill.
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00090, 32'd0);
      tick();
      chk("t5_req", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_req_drop", 32'(mem_req), 32'd0);
      tick();
      rst = 1'b0;
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00010, 32'd0);
      chk("t5_remiss", 32'(d_cache_status), 32'(D_CACHE_STALL));
      tick();
      chk("t5_rf_addr", 32'(mem_addr), 32'h004);
      chk("t5_rf_we", 32'(mem_we), 32'd0);
      mem_done(32'hCAFEF00D);
      chk("t5_data", mem_data, 32'hCAFEF00D);

      // Idle with stray mem_ready pulses.
      req(D_CACHE_NOP, FOUR_BYTE, 17'h00010, 32'd0);
      for (int i = 0; i < 10; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         tick();
         chk("t6_status", 32'(d_cache_status), 32'(D_CACHE_RESTING));
         chk("t6_req", 32'(mem_req), 32'd0);
      end
      mem_ready = 1'b0;
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00010, 32'd0);
      chk("t6_hit", 32'(d_cache_status), 32'(D_CACHE_RESTING));
      chk("t6_data", mem_data, 32'hCAFEF00D);
      req(D_CACHE_LOAD, FOUR_BYTE, 17'h00022, 32'd0);
      chk("t6_miss", 32'(d_cache_status), 32'(D_CACHE_STALL));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
